mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the pipeline. Consumes the EX/MEM pipeline register outputs: address from ALU result, store data from RB, destination register, RAM control, load select and register-file load enable.
- Performs big-endian byte, halfword and word loads and stores to an internal data RAM.
- Selects the stage result (load data or ALU result) and registers it, together with the destination and write enable, into the MEM/WB boundary.
- Also exports an unregistered stage result for the forwarding unit.

Parameters:
- ADDR_BITS, 8, byte-address width of the data RAM (depth = 2**ADDR_BITS bytes); upper address bits are ignored.

Ports:
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- MEM_RB_in  in  32  store data
- MEM_ALU_OUT_in  in  32  effective address / non-load result
- MEM_RD_in  in  5  destination register
- MEM_RAM_CTRL_in  in  4  [3]=E enable, [2]=RW (1 = store), [1:0]=size (00 byte, 01 half, 10 word, 11 reserved)
- MEM_L_in  in  1  1 = result is load data, 0 = ALU result
- MEM_RF_LE_in  in  1  register-file write enable
- MEM_FWD_RESULT_out  out  32  combinational stage result, for forwarding
- WB_RESULT_out  out  32  registered result
- WB_RD_out  out  5  registered destination
- WB_RF_LE_out  out  1  registered write enable
- MISALIGN_out  out  1  sticky misaligned-access flag

Behaviour:
- Address decode:
  - A = MEM_ALU_OUT_in[ADDR_BITS-1:0]; wraps modulo depth.
  - Byte at A is the most significant byte (big-endian).
- Alignment:
  - Halfword requires A[0]=0.
  - Word requires A[1:0]=00.
  - Byte is always aligned.
- Misaligned or reserved-size access (E=1): RAM not written; load data = 0.
- MISALIGN_out:
  - Set at the next rising edge on any misaligned access with E=1 (reserved size does not set it).
  - Sticky until Reset.
- Store (E=1, RW=1, aligned):
  - RAM bytes written at the rising edge while the instruction is present.
  - Byte: RB[7:0] to A.
  - Half: RB[15:8] to A, RB[7:0] to A+1.
  - Word: RB[31:24]..RB[7:0] to A..A+3.
  - No other byte is modified.
- Load (E=1, RW=0, aligned):
  - Combinational read, zero-extended.
  - Byte: {24'b0, M[A]}.
  - Half: {16'b0, M[A], M[A+1]}.
  - Word: {M[A], M[A+1], M[A+2], M[A+3]}.
- E=0: no RAM access; load data = 0.
- Result mux:
  - MEM_FWD_RESULT_out = MEM_L_in ? load data : MEM_ALU_OUT_in.
  - MEM_L_in=1 with E=0 yields 0.
- MEM/WB registers:
  - On each rising edge: WB_RESULT_out <= MEM_FWD_RESULT_out; WB_RD_out <= MEM_RD_in; WB_RF_LE_out <= MEM_RF_LE_in.
  - Total latency 1 cycle.
- Store followed by load of the same address in the next cycle returns the new data (write completed at the prior edge).
- Store instructions pass MEM_RF_LE_in unmodified; the decoder guarantees it is 0.
- Reset asserted (Reset=0), asynchronously:
  - WB_RESULT_out=0, WB_RD_out=0, WB_RF_LE_out=0, MISALIGN_out=0.
  - No RAM write occurs while Reset=0, including a store present at the same edge.
  - RAM contents are not cleared and are undefined after power-up.
- Reset deassertion is synchronised by the system; the first capture is at the first rising edge with Reset=1.

Test Plan:
- Reset 0 mid-stream with store word pending at next edge -> all outputs 0 immediately without a clock; after release, load word at that address shows the old contents.
- Store word 0xDEADBEEF at A=0x10, next cycle load word 0x10 with L=1 -> WB_RESULT_out=0xDEADBEEF one cycle later; load byte 0x11 -> 0x000000AD; load half 0x12 -> 0x0000BEEF.
- Store byte 0x5A at 0x13 over the previous word -> load word 0x10 = 0xDEADBE5A; bytes 0x10-0x12 unchanged.
- Load half at 0x11 -> result 0, MISALIGN_out=1 after the edge and stays 1; store word at 0x0E -> RAM unchanged; reserved size 11 -> no write, flag unaffected on a fresh reset.
- ALU path: L=0, E=0, ALU_OUT=0x12345678, RD=7, RF_LE=1 -> MEM_FWD_RESULT_out=0x12345678 same cycle; WB outputs 0x12345678/7/1 next edge.
- Wrap: ADDR_BITS=8, store word 0xCAFEF00D at address 0x00000104 -> load word at 0x04 returns 0xCAFEF00D.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: big-endian byte/half/word access to a local data RAM,
// result select, and the MEM/WB pipeline registers.
module mem_stage #(
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] MEM_RB_in,
  input  logic [31:0] MEM_ALU_OUT_in,
  input  logic [4:0]  MEM_RD_in,
  input  logic [3:0]  MEM_RAM_CTRL_in,
  input  logic        MEM_L_in,
  input  logic        MEM_RF_LE_in,
  output logic [31:0] MEM_FWD_RESULT_out,
  output logic [31:0] WB_RESULT_out,
  output logic [4:0]  WB_RD_out,
  output logic        WB_RF_LE_out,
  output logic        MISALIGN_out
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef logic [ADDR_BITS-1:0] addr_t;

  logic [7:0]  r_mem [DEPTH];
  logic [31:0] r_wb_result;
  logic [4:0]  r_wb_rd;
  logic        r_wb_le;
  logic        r_misalign;

  logic        w_en;
  logic        w_rw;
  logic        w_is_b;
  logic        w_is_h;
  logic        w_is_w;
  addr_t       w_a0;
  addr_t       w_a1;
  addr_t       w_a2;
  addr_t       w_a3;
  logic        w_aligned;
  logic        w_misalign;
  logic        w_acc;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_load;
  logic [31:0] w_result;

  assign w_en   = MEM_RAM_CTRL_in[3];
  assign w_rw   = MEM_RAM_CTRL_in[2];
  assign w_is_b = MEM_RAM_CTRL_in[1:0] == 2'b00;
  assign w_is_h = MEM_RAM_CTRL_in[1:0] == 2'b01;
  assign w_is_w = MEM_RAM_CTRL_in[1:0] == 2'b10;

  // Byte lanes; address arithmetic wraps modulo the RAM depth.
  assign w_a0 = MEM_ALU_OUT_in[ADDR_BITS-1:0];
  assign w_a1 = w_a0 + addr_t'(1);
  assign w_a2 = w_a0 + addr_t'(2);
  assign w_a3 = w_a0 + addr_t'(3);

  // Alignment check; the reserved size is never aligned but is not
  // reported as misaligned either.
  always_comb begin
    w_aligned  = 1'b0;
    w_misalign = 1'b0;
    unique case (1'b1)
      w_is_b: w_aligned = 1'b1;
      w_is_h: begin
        w_aligned  = ~w_a0[0];
        w_misalign = w_a0[0];
      end
      w_is_w: begin
        w_aligned  = w_a0[1:0] == 2'b00;
        w_misalign = w_a0[1:0] != 2'b00;
      end
      default: begin
        w_aligned  = 1'b0;
        w_misalign = 1'b0;
      end
    endcase
  end

  assign w_acc = w_en & w_aligned;
  assign w_wr  = w_acc & w_rw;
  assign w_rd  = w_acc & ~w_rw;

  // Combinational zero-extended big-endian read.
  always_comb begin
    w_load = 32'h0;
    if (w_rd) begin
      unique case (1'b1)
        w_is_b: w_load = {24'h0, r_mem[w_a0]};
        w_is_h: w_load = {16'h0, r_mem[w_a0], r_mem[w_a1]};
        w_is_w: w_load = {r_mem[w_a0], r_mem[w_a1],
                          r_mem[w_a2], r_mem[w_a3]};
        default: w_load = 32'h0;
      endcase
    end
  end

  assign w_result = MEM_L_in ? w_load : MEM_ALU_OUT_in;

  // RAM write port; contents survive reset, writes blocked while in reset.
  always_ff @(posedge clk) begin
    if (Reset && w_wr) begin
      unique case (1'b1)
        w_is_b: r_mem[w_a0] <= MEM_RB_in[7:0];
        w_is_h: begin
          r_mem[w_a0] <= MEM_RB_in[15:8];
          r_mem[w_a1] <= MEM_RB_in[7:0];
        end
        w_is_w: begin
          r_mem[w_a0] <= MEM_RB_in[31:24];
          r_mem[w_a1] <= MEM_RB_in[23:16];
          r_mem[w_a2] <= MEM_RB_in[15:8];
          r_mem[w_a3] <= MEM_RB_in[7:0];
        end
        default: ;
      endcase
    end
  end

  // MEM/WB boundary registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_wb_result <= 32'h0;
      r_wb_rd     <= 5'h0;
      r_wb_le     <= 1'b0;
    end else begin
      r_wb_result <= w_result;
      r_wb_rd     <= MEM_RD_in;
      r_wb_le     <= MEM_RF_LE_in;
    end
  end

  // Sticky misaligned-access flag.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_misalign <= 1'b0;
    end else if (w_en && w_misalign) begin
      r_misalign <= 1'b1;
    end
  end

  assign MEM_FWD_RESULT_out = w_result;
  assign WB_RESULT_out      = r_wb_result;
  assign WB_RD_out          = r_wb_rd;
  assign WB_RF_LE_out       = r_wb_le;
  assign MISALIGN_out       = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a result scoreboard
// covering loads, stores, alignment, wrap and async reset.
module tb_mem_stage;

  logic        clk;
  logic        Reset;
  logic [31:0] MEM_RB_in;
  logic [31:0] MEM_ALU_OUT_in;
  logic [4:0]  MEM_RD_in;
  logic [3:0]  MEM_RAM_CTRL_in;
  logic        MEM_L_in;
  logic        MEM_RF_LE_in;
  logic [31:0] MEM_FWD_RESULT_out;
  logic [31:0] WB_RESULT_out;
  logic [4:0]  WB_RD_out;
  logic        WB_RF_LE_out;
  logic        MISALIGN_out;

  int n_pass  = 0;
  int n_total = 0;

  logic [37:0] sb_q[$];

  localparam logic [3:0] SW  = 4'b1110;
  localparam logic [3:0] SH  = 4'b1101;
  localparam logic [3:0] SB  = 4'b1100;
  localparam logic [3:0] SR  = 4'b1111;
  localparam logic [3:0] LW  = 4'b1010;
  localparam logic [3:0] LH  = 4'b1001;
  localparam logic [3:0] LB  = 4'b1000;
  localparam logic [3:0] LR  = 4'b1011;
  localparam logic [3:0] OFF = 4'b0000;

  mem_stage #(.ADDR_BITS(8)) dut (
    .clk                (clk),
    .Reset              (Reset),
    .MEM_RB_in          (MEM_RB_in),
    .MEM_ALU_OUT_in     (MEM_ALU_OUT_in),
    .MEM_RD_in          (MEM_RD_in),
    .MEM_RAM_CTRL_in    (MEM_RAM_CTRL_in),
    .MEM_L_in           (MEM_L_in),
    .MEM_RF_LE_in       (MEM_RF_LE_in),
    .MEM_FWD_RESULT_out (MEM_FWD_RESULT_out),
    .WB_RESULT_out      (WB_RESULT_out),
    .WB_RD_out          (WB_RD_out),
    .WB_RF_LE_out       (WB_RF_LE_out),
    .MISALIGN_out       (MISALIGN_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    MEM_RB_in       = 32'h0;
    MEM_ALU_OUT_in  = 32'h0;
    MEM_RD_in       = 5'h0;
    MEM_RAM_CTRL_in = OFF;
    MEM_L_in        = 1'b0;
    MEM_RF_LE_in    = 1'b0;
  endtask

  // One instruction through the stage: forward value checked in the
  // same cycle, WB values checked from the scoreboard after the edge.
  task automatic step(input string tag, input logic [31:0] rb,
                      input logic [31:0] alu, input logic [4:0] rd,
                      input logic [3:0] ctrl, input logic l,
                      input logic le, input logic [31:0] exp);
    logic [37:0] e;
    @(negedge clk);
    MEM_RB_in       = rb;
    MEM_ALU_OUT_in  = alu;
    MEM_RD_in       = rd;
    MEM_RAM_CTRL_in = ctrl;
    MEM_L_in        = l;
    MEM_RF_LE_in    = le;
    #1;
    chk({tag, ".fwd"}, MEM_FWD_RESULT_out, exp);
    sb_q.push_back({exp, rd, le});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".wb_res"}, WB_RESULT_out, e[37:6]);
    chk({tag, ".wb_rd"}, {27'h0, WB_RD_out}, {27'h0, e[5:1]});
    chk({tag, ".wb_le"}, {31'h0, WB_RF_LE_out}, {31'h0, e[0]});
  endtask

  initial begin
    idle();
    Reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.res", WB_RESULT_out, 32'h0);
    chk("rst.rd", {27'h0, WB_RD_out}, 32'h0);
    chk("rst.le", {31'h0, WB_RF_LE_out}, 32'h0);
    chk("rst.mis", {31'h0, MISALIGN_out}, 32'h0);
    @(negedge clk);
    Reset = 1'b1;

    step("sw20", 32'h11223344, 32'h20, 5'd0, SW, 1'b0, 1'b0, 32'h20);
    step("alu55", 32'h0, 32'h55, 5'd9, OFF, 1'b0, 1'b1, 32'h55);

    // Async reset mid-stream with a store word pending.
    @(negedge clk);
    MEM_RB_in       = 32'h99999999;
    MEM_ALU_OUT_in  = 32'h20;
    MEM_RD_in       = 5'd2;
    MEM_RAM_CTRL_in = SW;
    #2;
    Reset = 1'b0;
    #1;
    chk("arst.res", WB_RESULT_out, 32'h0);
    chk("arst.rd", {27'h0, WB_RD_out}, 32'h0);
    chk("arst.le", {31'h0, WB_RF_LE_out}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle();
    Reset = 1'b1;
    step("lw20", 32'h0, 32'h20, 5'd4, LW, 1'b1, 1'b1, 32'h11223344);

    step("swdead", 32'hDEADBEEF, 32'h10, 5'd0, SW, 1'b0, 1'b0, 32'h10);
    step("lw10", 32'h0, 32'h10, 5'd5, LW, 1'b1, 1'b1, 32'hDEADBEEF);
    step("lb11", 32'h0, 32'h11, 5'd6, LB, 1'b1, 1'b1, 32'h000000AD);
    step("lh12", 32'h0, 32'h12, 5'd7, LH, 1'b1, 1'b1, 32'h0000BEEF);

    step("sb13", 32'hFFFFFF5A, 32'h13, 5'd0, SB, 1'b0, 1'b0, 32'h13);
    step("lw10b", 32'h0, 32'h10, 5'd8, LW, 1'b1, 1'b1, 32'hDEADBE5A);
    step("lh10", 32'h0, 32'h10, 5'd8, LH, 1'b1, 1'b1, 32'h0000DEAD);
    step("lb12", 32'h0, 32'h12, 5'd8, LB, 1'b1, 1'b1, 32'h000000BE);

    step("sh30", 32'hAAAA1234, 32'h30, 5'd0, SH, 1'b0, 1'b0, 32'h30);
    step("lb31", 32'h0, 32'h31, 5'd3, LB, 1'b1, 1'b1, 32'h00000034);

    // Reserved size: no write, no flag, load data zero.
    step("sres", 32'h0, 32'h10, 5'd0, SR, 1'b0, 1'b0, 32'h10);
    chk("res.mis", {31'h0, MISALIGN_out}, 32'h0);
    step("lres", 32'h0, 32'h10, 5'd1, LR, 1'b1, 1'b1, 32'h0);
    chk("res2.mis", {31'h0, MISALIGN_out}, 32'h0);
    step("lw10c", 32'h0, 32'h10, 5'd1, LW, 1'b1, 1'b1, 32'hDEADBE5A);

    step("sw0c", 32'h01020304, 32'h0C, 5'd0, SW, 1'b0, 1'b0, 32'h0C);
    chk("pre.mis", {31'h0, MISALIGN_out}, 32'h0);

    // Misaligned half load.
    step("lh11", 32'h0, 32'h11, 5'd2, LH, 1'b1, 1'b1, 32'h0);
    chk("lh11.mis", {31'h0, MISALIGN_out}, 32'h1);

    // Misaligned store word must leave RAM untouched.
    step("sw0e", 32'hFFFFFFFF, 32'h0E, 5'd0, SW, 1'b0, 1'b0, 32'h0E);
    chk("sw0e.mis", {31'h0, MISALIGN_out}, 32'h1);
    step("lw0c", 32'h0, 32'h0C, 5'd3, LW, 1'b1, 1'b1, 32'h01020304);
    step("lw10d", 32'h0, 32'h10, 5'd3, LW, 1'b1, 1'b1, 32'hDEADBE5A);
    chk("stick.mis", {31'h0, MISALIGN_out}, 32'h1);

    // ALU path and load with E=0.
    step("alu", 32'h0, 32'h12345678, 5'd7, OFF, 1'b0, 1'b1, 32'h12345678);
    step("le0", 32'h0, 32'h10, 5'd9, OFF, 1'b1, 1'b1, 32'h0);

    // Address wrap modulo 256.
    step("swwrap", 32'hCAFEF00D, 32'h104, 5'd0, SW, 1'b0, 1'b0, 32'h104);
    step("lw04", 32'h0, 32'h04, 5'd10, LW, 1'b1, 1'b1, 32'hCAFEF00D);
    step("lb107", 32'h0, 32'h107, 5'd11, LB, 1'b1, 1'b1, 32'h0000000D);

    // Flag clears only on reset.
    @(negedge clk);
    idle();
    Reset = 1'b0;
    #1;
    chk("clr.mis", {31'h0, MISALIGN_out}, 32'h0);
    @(negedge clk);
    Reset = 1'b1;
    step("lw04b", 32'h0, 32'h04, 5'd12, LW, 1'b1, 1'b0, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
